frame_pixel_source: RTL and testbench

- Raster-order pixel transmitter feeding the 5x5 separable Gaussian stage.
- Reads an 8-bit greyscale frame from a synchronous frame-buffer RAM (1-cycle read latency).
- Drives the Gaussian's pixel input and clock-enable, plus row/column position and frame markers.
- Optionally appends zero pixels so the Gaussian's line buffers drain after the last real pixel.

---
 rtl/sift_pkg.sv | 27 ++
 rtl/raster_ctr.sv | 42 ++++
 rtl/frame_pixel_source.sv | 176 +++++++++++++++++
 tb/tb_frame_pixel_source.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared types and constants for the frame pixel source feeding the
// 5x5 separable Gaussian stage.
package sift_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 400;
    localparam int DEF_IMG_H = 300;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FLUSH,
        DONE
    } src_state_t;

    // Zero pixels needed to push the last real row through both Gaussian passes.
    function automatic int flush_len(input int w);
        return 2 * w + 2;
    endfunction

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_ctr.sv
// Raster-order column/row counter. Advances one position per enabled cycle,
// wraps the column at W-1 (bumping the row) and the row at H-1, and flags
// the last position of the frame.
module raster_ctr
    import sift_pkg::*;
#(
    parameter int W  = DEF_IMG_W,
    parameter int H  = DEF_IMG_H,
    parameter int CW = cnt_w(W),
    parameter int RW = cnt_w(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic last_col;
    logic last_row;

    assign last_col = (col == CW'(W - 1));
    assign last_row = (row == RW'(H - 1));
    assign last     = last_col && last_row;

    // Position register: column wraps into the next row, row wraps to the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_pixel_source.sv
// Raster-order pixel transmitter: reads a greyscale frame from a synchronous
// frame-buffer RAM and streams it to the Gaussian stage with position tags
// and frame markers. Build option FRAME_SRC_FLUSH_EN appends zero pixels
// after the frame so the Gaussian line buffers drain.
module frame_pixel_source
    import sift_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int ADDR_W    = 17,
    parameter int BASE_ADDR = 0,
    localparam int COL_W    = cnt_w(IMG_W),
    localparam int ROW_W    = cnt_w(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_en,
    output logic [COL_W-1:0]  pix_col,
    output logic [ROW_W-1:0]  pix_row,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done
);

    src_state_t        state, state_nxt;
    logic [COL_W-1:0]  rd_col, out_col;
    logic [ROW_W-1:0]  rd_row, out_row;
    logic              rd_last, out_last;
    logic              fl_issue;
    logic              vld_p0, flush_p0, real_p0;
    logic              lastpix_p1;
    logic [ADDR_W-1:0] addr_calc;

    // Read-side position: advances once per issued frame-buffer read.
    raster_ctr #(.W(IMG_W), .H(IMG_H), .CW(COL_W), .RW(ROW_W)) u_rd_ctr (
        .clk  (clk),
        .rst  (rst),
        .en   (rd_en),
        .col  (rd_col),
        .row  (rd_row),
        .last (rd_last)
    );

    // Output-side position: tracks the real pixel currently entering the output register.
    raster_ctr #(.W(IMG_W), .H(IMG_H), .CW(COL_W), .RW(ROW_W)) u_out_ctr (
        .clk  (clk),
        .rst  (rst),
        .en   (real_p0),
        .col  (out_col),
        .row  (out_row),
        .last (out_last)
    );

    assign addr_calc = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_row) * ADDR_W'(IMG_W) + ADDR_W'(rd_col);
    assign rd_addr   = (state == READ) ? addr_calc : '0;
    assign real_p0   = vld_p0 && !flush_p0;

`ifdef FRAME_SRC_FLUSH_EN
    localparam int FL_LEN = flush_len(IMG_W);
    localparam int FL_W   = $clog2(FL_LEN + 1);

    logic [FL_W-1:0] fl_cnt;
    logic            fl_end;

    assign fl_end   = (fl_cnt == FL_W'(FL_LEN));
    assign fl_issue = (state == FLUSH) && !stall && !fl_end;

    // Counts zero pixels issued during FLUSH; cleared in every other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fl_cnt <= '0;
        end else if (state != FLUSH) begin
            fl_cnt <= '0;
        end else if (fl_issue) begin
            fl_cnt <= fl_cnt + 1'b1;
        end
    end
`else
    assign fl_issue = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and read/status strobes. DRAIN waits until the final
    // real pixel sits on the output so frame_done lands the cycle after it.
    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en = 1'b1;
                    if (rd_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (lastpix_p1) begin
`ifdef FRAME_SRC_FLUSH_EN
                    state_nxt = FLUSH;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FLUSH: begin
                busy = 1'b1;
`ifdef FRAME_SRC_FLUSH_EN
                if (fl_end && !vld_p0) state_nxt = DONE;
`else
                state_nxt = DONE;
`endif
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: issue flags aligned with rd_data returning from the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0   <= 1'b0;
            flush_p0 <= 1'b0;
        end else begin
            vld_p0   <= rd_en || fl_issue;
            flush_p0 <= fl_issue;
        end
    end

    // Stage p1: registered pixel, strobe, position tags and markers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en     <= 1'b0;
            pix_out    <= '0;
            pix_col    <= '0;
            pix_row    <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            lastpix_p1 <= 1'b0;
        end else begin
            pix_en     <= vld_p0;
            sof        <= real_p0 && (out_col == '0) && (out_row == '0);
            eol        <= real_p0 && (out_col == COL_W'(IMG_W - 1));
            lastpix_p1 <= real_p0 && out_last;
            if (vld_p0) begin
                pix_out <= flush_p0 ? '0 : rd_data;
                pix_col <= flush_p0 ? '0 : out_col;
                pix_row <= flush_p0 ? '0 : out_row;
            end
        end
    end

endmodule

// File: tb/tb_frame_pixel_source.sv
// Directed bench for frame_pixel_source with a 4x3 frame at base address 16;
// the RAM model returns the low address byte as data.
module tb_frame_pixel_source;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 17;
    localparam int BASE = 16;
    localparam int NPIX = W * H;
`ifdef FRAME_SRC_FLUSH_EN
    localparam int FL = 2 * W + 2;
`else
    localparam int FL = 0;
`endif

    logic          clk, rst, start, stall;
    logic          rd_en, pix_en, sof, eol, busy, frame_done;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data, pix_out;
    logic [1:0]    pix_col, pix_row;

    typedef struct {
        int v;
        int col;
        int row;
        int sof;
        int eol;
        int c;
    } pix_t;

    pix_t px_q[$];
    int   rd_a[$];
    int   rd_c[$];
    int   done_n;
    int   done_c;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    frame_pixel_source #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pix_out    (pix_out),
        .pix_en     (pix_en),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, one-cycle read latency, data = addr[7:0].
    always @(posedge clk) begin
        if (rd_en) rd_data <= rd_addr[7:0];
    end

    // Record reads, pixels and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (rd_en) begin
            rd_a.push_back(int'(rd_addr));
            rd_c.push_back(cyc);
        end
        if (pix_en)
            px_q.push_back('{int'(pix_out), int'(pix_col), int'(pix_row), int'(sof), int'(eol), cyc});
        if (frame_done) begin
            done_n = done_n + 1;
            done_c = cyc;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        px_q.delete();
        rd_a.delete();
        rd_c.delete();
        done_n = 0;
        done_c = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            if (frame_done) begin
                seen = 1'b1;
                check_val("busy_in_done", int'(busy), 0);
                if (poke_start) pulse_start();
            end
        end
        if (!seen) check_val("done_timeout", 0, 1);
    endtask

    task automatic wait_read(input int addr);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk); #1;
            if (rd_en && int'(rd_addr) == addr) seen = 1'b1;
        end
        if (!seen) check_val("read_timeout", 0, addr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_strobes"}, int'({rd_en, pix_en, busy, frame_done, sof, eol}), 0);
        check_val({tag, "_rd_addr"}, int'(rd_addr), 0);
        check_val({tag, "_pix_out"}, int'(pix_out), 0);
        check_val({tag, "_pos"}, int'({pix_col, pix_row}), 0);
    endtask

    task automatic check_frame(input bit contig);
        int n;
        check_val("rd_count", rd_a.size(), NPIX);
        n = (rd_a.size() < NPIX) ? rd_a.size() : NPIX;
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("rd_addr[%0d]", i), rd_a[i], BASE + i);
            if (contig) check_val($sformatf("rd_cyc[%0d]", i), rd_c[i] - rd_c[0], i);
        end
        check_val("pix_count", px_q.size(), NPIX + FL);
        if (px_q.size() > 0 && rd_c.size() > 0)
            check_val("latency", px_q[0].c - rd_c[0], 2);
        for (int i = 0; i < px_q.size(); i++) begin
            if (i < NPIX) begin
                check_val($sformatf("pix[%0d]", i), px_q[i].v, BASE + i);
                check_val($sformatf("col[%0d]", i), px_q[i].col, i % W);
                check_val($sformatf("row[%0d]", i), px_q[i].row, i / W);
                check_val($sformatf("sof[%0d]", i), px_q[i].sof, int'(i == 0));
                check_val($sformatf("eol[%0d]", i), px_q[i].eol, int'(i % W == W - 1));
            end else begin
                check_val($sformatf("flush_pix[%0d]", i), px_q[i].v, 0);
                check_val($sformatf("flush_tags[%0d]", i),
                          px_q[i].sof + px_q[i].eol + px_q[i].col + px_q[i].row, 0);
            end
        end
        check_val("done_count", done_n, 1);
        if (px_q.size() > 0)
            check_val("done_cyc", done_c - px_q[px_q.size() - 1].c, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int nwin;
        int vwin;
        int nrd;

        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");

        rst = 1'b1;
        @(posedge clk); #1;

        // Frame 1: plain frame, extra start mid-frame and in the DONE cycle.
        clear_log();
        pulse_start();
        check_val("busy_after_start", int'(busy), 1);
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        wait_done(1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_frame(1'b1);
        check_val("idle_after_done", int'(busy), 0);

        // Frame 2: three stall cycles right after the read of address 21.
        clear_log();
        pulse_start();
        wait_read(21);
        @(posedge clk); #1;
        stall = 1'b1;
        s = cyc;
        #1;
        check_val("stall_rd_en", int'(rd_en), 0);
        check_val("stall_addr_hold", int'(rd_addr), 22);
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        wait_done(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_frame(1'b0);
        nwin = 0;
        vwin = -1;
        foreach (px_q[i]) begin
            if (px_q[i].c >= s + 1 && px_q[i].c <= s + 4) begin
                nwin++;
                vwin = px_q[i].v;
            end
        end
        check_val("stall_window_count", nwin, 1);
        check_val("stall_window_pix", vwin, 21);
        nrd = 0;
        foreach (rd_c[i]) if (rd_c[i] >= s && rd_c[i] <= s + 2) nrd++;
        check_val("stall_reads", nrd, 0);
        if (rd_a.size() > 6) check_val("resume_cyc", rd_c[6] - s, 3);

        // Frame 3: reset during row 1, then a clean restart.
        clear_log();
        pulse_start();
        wait_read(22);
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (20) @(posedge clk);
        #1;
        check_val("midrst_no_done", done_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_log();
        pulse_start();
        wait_done(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_frame(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
